// File: rtl/uart_tx_front.sv
// uart_tx_front: UART 8N1 transmitter with a one-entry holding register.
//
// A byte accepted on the valid/ready handshake is sent on uart_tx as:
// a start bit (0), 8 data bits LSB first, and a stop bit (1). Each bit lasts
// CLKS_PER_BIT clocks. A second byte may be queued while a frame is on the
// line; it goes out directly after the stop bit with no idle gap.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous, active-low reset
//   uart_tx    serial line, idle high, registered
//   data_tx    byte to send, sampled only on the accepting edge
//   tx_valid   producer has a byte on data_tx
//   tx_ready   block can accept a byte this cycle (holding register empty)
//   tx_busy    a frame is on the line or a byte is queued
//   state_dbg  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: a byte transfers on a rising edge where tx_valid and tx_ready
// are both 1. tx_valid with tx_ready=0 is simply held off; nothing is lost
// and data_tx is ignored on every edge except the accepting one.

module uart_tx_front #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       uart_tx,
  input  logic [7:0] data_tx,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic [1:0] state_dbg
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [7:0]    hold_data;
  logic          hold_full;

  logic bit_end;
  logic shifter_avail;
  logic accept;

  assign bit_end       = (baud_cnt == BAUD_LAST);
  // The shifter can take a new byte when idle, or on the last cycle of the
  // stop bit so the next start bit follows with zero idle cycles.
  assign shifter_avail = (state == IDLE) || ((state == STOP) && bit_end);
  assign tx_ready      = !hold_full;
  assign accept        = tx_valid && tx_ready;
  assign tx_busy       = (state != IDLE) || hold_full;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      uart_tx   <= 1'b1;
    end else begin
      // A byte arriving while the shifter is occupied is parked. The hold
      // register is only written when it is empty (accept implies ready),
      // so this never collides with the unload in STOP below.
      if (accept && !shifter_avail) begin
        hold_data <= data_tx;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (accept) begin
            shift_reg <= data_tx;
            state     <= START;
            uart_tx   <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            uart_tx  <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            bit_cnt   <= bit_cnt + 3'd1;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              // Bit k+1 is shift_reg[1] before this edge's shift.
              uart_tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (hold_full) begin
              shift_reg <= hold_data;
              hold_full <= 1'b0;
              state     <= START;
              uart_tx   <= 1'b0;
            end else if (accept) begin
              shift_reg <= data_tx;
              state     <= START;
              uart_tx   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_front.sv
// tb_uart_tx_front: self-checking bench for uart_tx_front.
//
// Two instances share the stimulus: dut_a (CLKS_PER_BIT=16) and dut_b
// (CLKS_PER_BIT=2); 'sel' picks which one is checked. The reference model
// keeps a list of frames (accept edge, first start edge, byte) and derives
// line level, tx_ready and tx_busy for every cycle from frame arithmetic.

module tb_uart_tx_front;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data_tx = 8'h00;
  logic       tx_valid = 1'b0;

  logic       tx_a, ready_a, busy_a;
  logic       tx_b, ready_b, busy_b;
  logic [1:0] st_a, st_b;

  always #5 clk = ~clk;

  uart_tx_front #(.CLKS_PER_BIT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .uart_tx(tx_a), .data_tx(data_tx),
    .tx_valid(tx_valid), .tx_ready(ready_a), .tx_busy(busy_a), .state_dbg(st_a)
  );

  uart_tx_front #(.CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .uart_tx(tx_b), .data_tx(data_tx),
    .tx_valid(tx_valid), .tx_ready(ready_b), .tx_busy(busy_b), .state_dbg(st_b)
  );

  logic sel = 1'b0;
  logic obs_line, obs_ready, obs_busy;
  assign obs_line  = sel ? tx_b    : tx_a;
  assign obs_ready = sel ? ready_b : ready_a;
  assign obs_busy  = sel ? busy_b  : busy_a;

  // ---------------- scoreboard / model ----------------
  int err_cnt = 0;
  int chk_cnt = 0;

  int         cyc = 0;       // index of the most recent rising edge
  int         cpb = 16;      // bit period of the instance under check
  int         fa[$];         // edge on which each byte was accepted
  int         fs[$];         // edge on which its start bit begins
  logic [7:0] fd[$];         // the byte itself
  logic [7:0] exp_q[$];      // bytes still to be offered by the driver
  logic       rand_on = 1'b0;
  logic       from_q  = 1'b0;

  logic m_ready = 1'b1;
  logic m_busy  = 1'b0;
  logic m_line  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Apply the handshake seen at edge 'cyc'. A new frame starts on the
  // accepting edge if the line is free, otherwise right when the previous
  // frame ends (10 bit periods after its start).
  task automatic model_edge();
    if (tx_valid && m_ready) begin
      int s;
      s = cyc;
      if (fs.size() > 0 && fs[$] + 10 * cpb > s) s = fs[$] + 10 * cpb;
      fa.push_back(cyc);
      fs.push_back(s);
      fd.push_back(data_tx);
      if (from_q && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  // Expected outputs in the cycle following edge 'cyc'.
  task automatic model_out();
    int idx;
    m_ready = 1'b1;
    m_busy  = 1'b0;
    m_line  = 1'b1;
    for (int i = 0; i < fs.size(); i++) begin
      if (fa[i] <= cyc && cyc < fs[i]) m_ready = 1'b0;
      if (fa[i] <= cyc && cyc < fs[i] + 10 * cpb) m_busy = 1'b1;
      if (fs[i] <= cyc && cyc < fs[i] + 10 * cpb) begin
        idx = (cyc - fs[i]) / cpb;
        if (idx == 0)      m_line = 1'b0;
        else if (idx == 9) m_line = 1'b1;
        else               m_line = fd[i][idx-1];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_next();
    if (exp_q.size() > 0) begin
      from_q   = 1'b1;
      tx_valid = 1'b1;
      // While held off, data_tx wanders so only the accepting edge counts.
      data_tx  = m_ready ? exp_q[0] : 8'($urandom);
    end else begin
      from_q   = 1'b0;
      tx_valid = rand_on ? ($urandom_range(0, 2) == 0) : 1'b0;
      data_tx  = 8'($urandom);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      model_out();
      check("uart_tx",  {31'd0, obs_line},  {31'd0, m_line});
      check("tx_ready", {31'd0, obs_ready}, {31'd0, m_ready});
      check("tx_busy",  {31'd0, obs_busy},  {31'd0, m_busy});
      drive_next();
    end
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    from_q   = 1'b0;
    #1;
    fa.delete();
    fs.delete();
    fd.delete();
    exp_q.delete();
    model_out();
    check("rst_uart_tx",  {31'd0, obs_line},  {31'd0, m_line});
    check("rst_tx_ready", {31'd0, obs_ready}, {31'd0, m_ready});
    check("rst_tx_busy",  {31'd0, obs_busy},  {31'd0, m_busy});
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #2;
    sel = 1'b0;
    cpb = 16;
    reset_dut();

    // Single 0x55 from idle, then let the line settle.
    exp_q.push_back(8'h55);
    drive_next();
    step(12 * 16);

    // Three bytes with tx_valid held: contiguous frames.
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h96);
    drive_next();
    step(32 * 16);

    // Reset during data bit 3 of 0xA5 with 0x3C queued behind it.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    drive_next();
    step(4 * 16 + 6);
    reset_dut();
    drive_next();
    step(12 * 16);

    // Random traffic with data_tx changing every cycle.
    rand_on = 1'b1;
    drive_next();
    step(2500);
    rand_on = 1'b0;
    drive_next();
    step(22 * 16);

    // Short bit period: 0x00 then 0xFF back-to-back, 40 cycles total.
    sel = 1'b1;
    cpb = 2;
    reset_dut();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    drive_next();
    step(50);

    rand_on = 1'b1;
    drive_next();
    step(600);
    rand_on = 1'b0;
    drive_next();
    step(50);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
